// File: rtl/lm32_dtlb_walker_pkg.sv
// Shared definitions for the LM32 data TLB refill walker.
// Provides the CSR index of the page-table base register, the PTE/PDE valid bit
// position and the walker state encoding.
package lm32_dtlb_walker_pkg;

  localparam int unsigned CsrRng = 5;

  localparam logic [CsrRng-1:0] Lm32CsrPtbr = 5'h14;

  // Bit that marks a directory or table entry as present.
  localparam int unsigned Lm32PteValidBit = 0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StL1     = 3'd1,
    StL2     = 3'd2,
    StUpdate = 3'd3,
    StFault  = 3'd4
  } walk_state_e;

endpackage

// File: rtl/lm32_dtlb_walker.sv
// Hardware refill engine for the LM32 data TLB.
// On a DTLB miss it walks a two-level page table over a Wishbone classic read
// master and emits a one-cycle vaddr/paddr update strobe for the DTLB.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   enable                  walker enable (MMU on)
//   miss_req, miss_vaddr    DTLB miss request (level) and faulting address
//   abort                   cancel a walk in progress (exception/flush)
//   csr, csr_write_data,
//   csr_write_enable        CSR access port; csr_read_data returns the PTBR
//   busy                    walk in progress
//   tlb_update_*            one-cycle DTLB entry write
//   walk_done, walk_fault   one-cycle completion pulses; fault_addr holds last fault vaddr
//   m_*                     Wishbone classic read master
module lm32_dtlb_walker
  import lm32_dtlb_walker_pkg::*;
#(
  parameter int unsigned page_size = 4096,
  parameter int unsigned l1_bits   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable,
  input  logic              miss_req,
  input  logic [31:0]       miss_vaddr,
  input  logic              abort,
  input  logic [CsrRng-1:0] csr,
  input  logic [31:0]       csr_write_data,
  input  logic              csr_write_enable,
  output logic [31:0]       csr_read_data,
  output logic              busy,
  output logic              tlb_update_stb,
  output logic [31:0]       tlb_update_vaddr,
  output logic [31:0]       tlb_update_paddr,
  output logic              walk_done,
  output logic              walk_fault,
  output logic [31:0]       fault_addr,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic [31:0]       m_adr_o,
  output logic [3:0]        m_sel_o,
  output logic              m_we_o,
  input  logic [31:0]       m_dat_i,
  input  logic              m_ack_i,
  input  logic              m_err_i
);

  localparam int unsigned Offset = $clog2(page_size);
  localparam int unsigned L2Bits = 32 - Offset - l1_bits;
  localparam int unsigned PfnW   = 32 - Offset;

  walk_state_e     state_q, state_d;
  logic [31:0]     vaddr_q, vaddr_d;
  logic [PfnW-1:0] base_q, base_d;   // PTBR snapshot taken when the walk starts
  logic [PfnW-1:0] pde_q, pde_d;
  logic [PfnW-1:0] pte_q, pte_d;
  logic [PfnW-1:0] ptbr_q, ptbr_d;
  logic [31:0]     fault_addr_q, fault_addr_d;
  logic            abort_q, abort_d; // abort seen while a bus cycle is in flight

  logic bus_done;
  logic entry_ok;
  logic [31:0] l1_adr;
  logic [31:0] l2_adr;

  logic unused_bits;
  assign unused_bits = ^{m_dat_i[Offset-1:1], csr_write_data[Offset-1:0]};

  assign bus_done = m_ack_i | m_err_i;
  // An error wins over a simultaneous ack.
  assign entry_ok = m_ack_i & ~m_err_i & m_dat_i[Lm32PteValidBit];

  assign l1_adr = {base_q, {Offset{1'b0}}}
                + {{(30 - l1_bits){1'b0}}, vaddr_q[31 -: l1_bits], 2'b00};
  // A second-level table occupies exactly one page, so L2Bits + 2 == Offset.
  assign l2_adr = {pde_q, vaddr_q[Offset +: L2Bits], 2'b00};

  // CSR: PTBR is page aligned; a write mid-walk only affects the next walk.
  always_comb begin
    ptbr_d = ptbr_q;
    if (csr_write_enable && (csr == Lm32CsrPtbr)) begin
      ptbr_d = csr_write_data[31:Offset];
    end
  end

  assign csr_read_data = (csr == Lm32CsrPtbr) ? {ptbr_q, {Offset{1'b0}}} : 32'h0;

  always_comb begin
    state_d      = state_q;
    vaddr_d      = vaddr_q;
    base_d       = base_q;
    pde_d        = pde_q;
    pte_d        = pte_q;
    fault_addr_d = fault_addr_q;
    abort_d      = abort_q;

    unique case (state_q)
      StIdle: begin
        if (enable && miss_req && !abort) begin
          vaddr_d = miss_vaddr;
          base_d  = ptbr_q;
          abort_d = 1'b0;
          state_d = StL1;
        end
      end
      StL1: begin
        if (bus_done) begin
          if (abort || abort_q) begin
            state_d = StIdle;
          end else if (entry_ok) begin
            pde_d   = m_dat_i[31:Offset];
            state_d = StL2;
          end else begin
            state_d = StFault;
          end
        end else if (abort) begin
          abort_d = 1'b1;
        end
      end
      StL2: begin
        if (bus_done) begin
          if (abort || abort_q) begin
            state_d = StIdle;
          end else if (entry_ok) begin
            pte_d   = m_dat_i[31:Offset];
            state_d = StUpdate;
          end else begin
            state_d = StFault;
          end
        end else if (abort) begin
          abort_d = 1'b1;
        end
      end
      StUpdate: begin
        state_d = StIdle;
      end
      StFault: begin
        fault_addr_d = vaddr_q;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      vaddr_q      <= 32'h0;
      base_q       <= '0;
      pde_q        <= '0;
      pte_q        <= '0;
      ptbr_q       <= '0;
      fault_addr_q <= 32'h0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      base_q       <= base_d;
      pde_q        <= pde_d;
      pte_q        <= pte_d;
      ptbr_q       <= ptbr_d;
      fault_addr_q <= fault_addr_d;
      abort_q      <= abort_d;
    end
  end

  // Outputs decode directly from state so an async reset drops cyc/stb at once.
  always_comb begin
    busy             = (state_q != StIdle);
    m_cyc_o          = 1'b0;
    m_stb_o          = 1'b0;
    m_adr_o          = 32'h0;
    tlb_update_stb   = 1'b0;
    tlb_update_vaddr = 32'h0;
    tlb_update_paddr = 32'h0;
    walk_done        = 1'b0;
    walk_fault       = 1'b0;
    unique case (state_q)
      StL1: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_adr_o = l1_adr;
      end
      StL2: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_adr_o = l2_adr;
      end
      StUpdate: begin
        tlb_update_stb   = 1'b1;
        walk_done        = 1'b1;
        tlb_update_vaddr = {vaddr_q[31:Offset], {Offset{1'b0}}};
        tlb_update_paddr = {pte_q, {Offset{1'b0}}};
      end
      StFault: begin
        walk_fault = 1'b1;
      end
      default: ;
    endcase
  end

  assign fault_addr = fault_addr_q;
  assign m_sel_o    = 4'hf;
  assign m_we_o     = 1'b0;

endmodule
